ram_bank: RTL

RAM_BANK -- requirements
Module: ram_bank

---
 rtl/ram_bank.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/ram_bank.sv
// ram_bank: single-port, byte-writable synchronous RAM with a hardware
// clear sweep and a configurable read pipeline.
//
// Parameters
//   DATA_W   word width (multiple of 8)
//   ADDR_W   address width, depth = 2**ADDR_W
//   RD_LAT   read latency in cycles (1 or 2)
//   RDW_MODE write returns old word (0) or merged new word (1)
//
// Ports
//   clka       clock, rising edge
//   rsta_n     asynchronous active-low reset
//   ena        request valid
//   wea        1 = write, 0 = read (qualified by ena)
//   bea        byte write enables
//   addra      word address
//   dina       write data
//   clr        pulse that starts a clear sweep (ignored while busy)
//   douta      read data, held while dvalida = 0
//   dvalida    pulses RD_LAT cycles after each accepted request
//   busy       high in INIT and during the clear sweep
//   parity_err (only with RAM_BANK_PARITY_EN) parity failure on a read
//
// Optional feature: define RAM_BANK_PARITY_EN to store one even-parity bit
// per byte and add the parity_err output.
module ram_bank #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned ADDR_W   = 6,
  parameter int unsigned RD_LAT   = 1,
  parameter int unsigned RDW_MODE = 0
) (
  input  logic                clka,
  input  logic                rsta_n,
  input  logic                ena,
  input  logic                wea,
  input  logic [DATA_W/8-1:0] bea,
  input  logic [ADDR_W-1:0]   addra,
  input  logic [DATA_W-1:0]   dina,
  input  logic                clr,
  output logic [DATA_W-1:0]   douta,
  output logic                dvalida,
`ifdef RAM_BANK_PARITY_EN
  output logic                parity_err,
`endif
  output logic                busy
);

  localparam int unsigned NB    = DATA_W / 8;
  localparam int unsigned DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W:0] LAST_ADDR = {1'b0, {ADDR_W{1'b1}}};

  typedef enum logic [1:0] {INIT, CLEAR, READY} state_t;

  state_t state_q, state_d;
  logic [ADDR_W:0] sweep_q, sweep_d;

  logic [DATA_W-1:0] mem [DEPTH];

  logic              accept;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] rd_word;
  logic [DATA_W-1:0] merged;
  logic [DATA_W-1:0] result;

  // Read pipeline: stage 0 is loaded from the array, last stage drives douta.
  // Each stage only takes new data when its input is valid, so douta holds.
  logic [DATA_W-1:0] pd_q [RD_LAT];
  logic [DATA_W-1:0] pd_d [RD_LAT];
  logic [RD_LAT-1:0] pv_q, pv_d;

`ifdef RAM_BANK_PARITY_EN
  logic [NB-1:0]     par_mem [DEPTH];
  logic [NB-1:0]     par_wdata;
  logic              rd_perr;
  logic [RD_LAT-1:0] pe_q, pe_d;
`endif

  assign accept  = (state_q == READY) && ena && !clr;
  assign rd_word = mem[addra];
  assign busy    = (state_q != READY);
  assign douta   = pd_q[RD_LAT-1];
  assign dvalida = pv_q[RD_LAT-1];

  always_comb begin
    merged = rd_word;
    for (int unsigned i = 0; i < NB; i++) begin
      if (bea[i]) merged[8*i +: 8] = dina[8*i +: 8];
    end
    result = (wea && (RDW_MODE != 0)) ? merged : rd_word;
  end

  // FSM next state and array write port. A clr in READY wins over a
  // same-edge request, which is dropped.
  always_comb begin
    state_d   = state_q;
    sweep_d   = sweep_q;
    mem_we    = 1'b0;
    mem_waddr = addra;
    mem_wdata = merged;
    case (state_q)
      INIT: begin
        state_d = CLEAR;
        sweep_d = '0;
      end
      CLEAR: begin
        mem_we    = 1'b1;
        mem_waddr = sweep_q[ADDR_W-1:0];
        mem_wdata = '0;
        sweep_d   = sweep_q + 1'b1;
        if (sweep_q == LAST_ADDR) state_d = READY;
      end
      READY: begin
        if (clr) begin
          state_d = CLEAR;
          sweep_d = '0;
        end else if (ena && wea) begin
          mem_we = 1'b1;
        end
      end
      default: state_d = INIT;
    endcase
  end

`ifdef RAM_BANK_PARITY_EN
  always_comb begin
    par_wdata = '0;
    rd_perr   = 1'b0;
    for (int unsigned i = 0; i < NB; i++) begin
      par_wdata[i] = ^mem_wdata[8*i +: 8];
      if ((^rd_word[8*i +: 8]) != par_mem[addra][i]) rd_perr = 1'b1;
    end
  end
`endif

  always_comb begin
    pv_d[0] = accept;
    pd_d[0] = accept ? result : pd_q[0];
    for (int unsigned i = 1; i < RD_LAT; i++) begin
      pv_d[i] = pv_q[i-1];
      pd_d[i] = pv_q[i-1] ? pd_q[i-1] : pd_q[i];
    end
`ifdef RAM_BANK_PARITY_EN
    pe_d[0] = accept && !wea && rd_perr;
    for (int unsigned i = 1; i < RD_LAT; i++) begin
      pe_d[i] = pe_q[i-1];
    end
`endif
  end

  always_ff @(posedge clka or negedge rsta_n) begin
    if (!rsta_n) begin
      state_q <= INIT;
      sweep_q <= '0;
      pv_q    <= '0;
      for (int unsigned i = 0; i < RD_LAT; i++) pd_q[i] <= '0;
`ifdef RAM_BANK_PARITY_EN
      pe_q    <= '0;
`endif
    end else begin
      state_q <= state_d;
      sweep_q <= sweep_d;
      pv_q    <= pv_d;
      for (int unsigned i = 0; i < RD_LAT; i++) pd_q[i] <= pd_d[i];
`ifdef RAM_BANK_PARITY_EN
      pe_q    <= pe_d;
`endif
    end
  end

`ifdef RAM_BANK_PARITY_EN
  assign parity_err = pe_q[RD_LAT-1];
`endif

  // Array storage is deliberately not reset; the post-reset sweep zeroes it.
  always_ff @(posedge clka) begin
    if (mem_we) begin
      mem[mem_waddr] <= mem_wdata;
`ifdef RAM_BANK_PARITY_EN
      par_mem[mem_waddr] <= par_wdata;
`endif
    end
  end

endmodule
